// File: rtl/multirate_mac_pipe.sv
// multirate_mac_pipe: pipelined multiply-accumulate for one polyphase FIR branch.
// Optional build macro SAT_EN: saturating output select with ovf flag (default: wrap, ovf tied 0).
module multirate_mac_pipe #(
    parameter int DIN0_WIDTH  = 16,
    parameter int DIN1_WIDTH  = 9,
    parameter int DIN1_SIGNED = 0,
    parameter int NUM_STAGE   = 2,
    parameter int ACC_WIDTH   = 32,
    parameter int DOUT_WIDTH  = 25,
    parameter int OUT_SHIFT   = 0
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    input  logic                  first,
    input  logic                  last,
    output logic                  out_valid,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  ovf
);
    localparam int PW = DIN0_WIDTH + DIN1_WIDTH + 1;

    logic signed [DIN1_WIDTH:0] w_din1_ext;
    logic signed [PW-1:0]       w_prod;

    generate
        if (DIN1_SIGNED != 0) begin : g_din1_signed
            assign w_din1_ext = $signed({din1[DIN1_WIDTH-1], din1});
        end else begin : g_din1_unsigned
            assign w_din1_ext = $signed({1'b0, din1});
        end
    endgenerate

    assign w_prod = PW'($signed(din0)) * PW'(w_din1_ext);

    // Index 0 is the combinational input; index NUM_STAGE feeds the accumulator.
    logic [NUM_STAGE:0][ACC_WIDTH-1:0] w_p_stage;
    logic [NUM_STAGE:0]                w_v_stage;
    logic [NUM_STAGE:0]                w_f_stage;
    logic [NUM_STAGE:0]                w_l_stage;

    assign w_p_stage[0] = ACC_WIDTH'(w_prod);
    assign w_v_stage[0] = in_valid;
    assign w_f_stage[0] = first;
    assign w_l_stage[0] = last;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGE; gi++) begin : g_stage
            logic [ACC_WIDTH-1:0] r_p;
            logic                 r_v;
            logic                 r_f;
            logic                 r_l;

            always_ff @(posedge ap_clk) begin
                if (ap_rst) begin
                    r_p <= '0;
                    r_v <= 1'b0;
                    r_f <= 1'b0;
                    r_l <= 1'b0;
                end else if (ce) begin
                    r_p <= w_p_stage[gi];
                    r_v <= w_v_stage[gi];
                    r_f <= w_f_stage[gi];
                    r_l <= w_l_stage[gi];
                end
            end

            assign w_p_stage[gi+1] = r_p;
            assign w_v_stage[gi+1] = r_v;
            assign w_f_stage[gi+1] = r_f;
            assign w_l_stage[gi+1] = r_l;
        end
    endgenerate

    logic signed [ACC_WIDTH-1:0] w_p;
    logic signed [ACC_WIDTH-1:0] w_acc_next;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic                        w_v;
    logic                        w_f;
    logic                        w_l;
    logic                        w_start;
    logic                        r_start_pending;
    logic                        r_out_valid;
    logic [DOUT_WIDTH-1:0]       r_dout;
    logic [DOUT_WIDTH-1:0]       w_sel;

    assign w_p = $signed(w_p_stage[NUM_STAGE]);
    assign w_v = w_v_stage[NUM_STAGE];
    assign w_f = w_f_stage[NUM_STAGE];
    assign w_l = w_l_stage[NUM_STAGE];

    // A group also restarts after reset or a completed group, even without first.
    assign w_start    = w_f | r_start_pending;
    assign w_acc_next = w_start ? w_p : r_acc + w_p;

`ifdef SAT_EN
    logic signed [ACC_WIDTH-1:0]    w_shifted;
    logic [ACC_WIDTH-DOUT_WIDTH:0]  w_hi;
    logic                           w_sat;
    logic                           r_ovf;

    assign w_shifted = w_acc_next >>> OUT_SHIFT;
    // In range only when every bit above the output sign bit matches it.
    assign w_hi      = w_shifted[ACC_WIDTH-1:DOUT_WIDTH-1];
    assign w_sat     = ~((&w_hi) | ~(|w_hi));
    assign w_sel     = !w_sat ? w_shifted[DOUT_WIDTH-1:0] :
                       (w_shifted[ACC_WIDTH-1] ? {1'b1, {(DOUT_WIDTH-1){1'b0}}}
                                               : {1'b0, {(DOUT_WIDTH-1){1'b1}}});

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_ovf <= 1'b0;
        end else if (ce) begin
            r_ovf <= w_v & w_l & w_sat;
        end
    end

    assign ovf = r_ovf;
`else
    assign w_sel = w_acc_next[OUT_SHIFT +: DOUT_WIDTH];
    assign ovf   = 1'b0;
`endif

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_acc           <= '0;
            r_start_pending <= 1'b1;
            r_out_valid     <= 1'b0;
            r_dout          <= '0;
        end else if (ce) begin
            if (w_v) begin
                r_acc           <= w_acc_next;
                r_start_pending <= w_l;
            end
            r_out_valid <= w_v & w_l;
            if (w_v & w_l) begin
                r_dout <= w_sel;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign dout      = r_dout;

endmodule

// File: tb/tb_multirate_mac_pipe.sv
// Scoreboard bench: two configurations of multirate_mac_pipe driven by the same tap stream.
module tb_multirate_mac_pipe;
    localparam int NS0 = 2;
    localparam int NS1 = 0;
    localparam int SH0 = 0;
    localparam int SH1 = 3;
    localparam int DW0 = 25;
    localparam int DW1 = 20;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic        ce = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] din0 = '0;
    logic [8:0]  din1 = '0;
    logic        first = 1'b0;
    logic        last = 1'b0;

    logic          out_valid0, ovf0, out_valid1, ovf1;
    logic [DW0-1:0] dout0;
    logic [DW1-1:0] dout1;

    always #5 ap_clk = ~ap_clk;

    multirate_mac_pipe u_dut0 (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .in_valid(in_valid),
        .din0(din0), .din1(din1), .first(first), .last(last),
        .out_valid(out_valid0), .dout(dout0), .ovf(ovf0)
    );

    multirate_mac_pipe #(
        .DIN1_SIGNED(1), .NUM_STAGE(NS1), .DOUT_WIDTH(DW1), .OUT_SHIFT(SH1)
    ) u_dut1 (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .in_valid(in_valid),
        .din0(din0), .din1(din1), .first(first), .last(last),
        .out_valid(out_valid1), .dout(dout1), .ovf(ovf1)
    );

    typedef struct {
        int     due;
        longint val;
        bit     ovf;
    } exp_t;

    exp_t   q0[$];
    exp_t   q1[$];
    int     tests_run = 0;
    int     failures = 0;
    int     en_edges = 0;
    bit     edge_en = 1'b0;
    bit     edge_rst = 1'b0;
    bit     pending = 1'b1;
    longint sum0 = 0;
    longint sum1 = 0;

    // Expected visible output state of each DUT, advanced by the monitor.
    bit     mv0 = 0, mv1 = 0, mo0 = 0, mo1 = 0;
    longint md0 = 0, md1 = 0;
    exp_t   e0, e1;
    bit     have0, have1;

    function automatic longint wrapw(input longint x, input int w);
        longint m;
        m = x & ((64'sd1 <<< w) - 1);
        if (m >= (64'sd1 <<< (w - 1))) m = m - (64'sd1 <<< w);
        return m;
    endfunction

    function automatic void model_out(input longint sum, input int sh, input int dw,
                                      output longint v, output bit o);
        longint s;
        longint lim;
        s   = wrapw(sum, 32) >>> sh;
        lim = 64'sd1 <<< (dw - 1);
`ifdef SAT_EN
        if (s > lim - 1) begin
            v = lim - 1; o = 1'b1;
        end else if (s < -lim) begin
            v = -lim; o = 1'b1;
        end else begin
            v = s; o = 1'b0;
        end
`else
        v = wrapw(s, dw);
        o = 1'b0;
`endif
    endfunction

    task automatic chk(input string nm, input longint act, input longint req);
        tests_run++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic model_tap(input logic [15:0] a, input logic [8:0] b, input bit f, input bit l);
        longint p0, p1, v;
        bit     o;
        exp_t   e;
        p0 = longint'($signed(a)) * longint'(b);
        p1 = longint'($signed(a)) * longint'($signed(b));
        if (f || pending) begin
            sum0 = p0; sum1 = p1;
        end else begin
            sum0 += p0; sum1 += p1;
        end
        pending = l;
        if (l) begin
            model_out(sum0, SH0, DW0, v, o);
            e.due = en_edges + NS0; e.val = v; e.ovf = o;
            q0.push_back(e);
            model_out(sum1, SH1, DW1, v, o);
            e.due = en_edges + NS1; e.val = v; e.ovf = o;
            q1.push_back(e);
        end
    endtask

    task automatic step(input bit rst, input bit c, input bit v, input logic [15:0] a,
                        input logic [8:0] b, input bit f, input bit l);
        ap_rst = rst; ce = c; in_valid = v; din0 = a; din1 = b; first = f; last = l;
        @(posedge ap_clk);
        edge_rst = rst;
        edge_en  = !rst && c;
        if (rst) begin
            q0.delete(); q1.delete();
            pending = 1'b1; sum0 = 0; sum1 = 0;
        end else if (c) begin
            en_edges++;
            if (v) model_tap(a, b, f, l);
        end
        #1;
    endtask

    task automatic tap(input logic [15:0] a, input logic [8:0] b, input bit f, input bit l);
        step(1'b0, 1'b1, 1'b1, a, b, f, l);
    endtask

    task automatic idle(input int n, input bit c);
        for (int i = 0; i < n; i++) step(1'b0, c, 1'b0, 16'h0, 9'h0, 1'b0, 1'b0);
    endtask

    // Monitor: pops an expectation whenever one is due on this enabled edge.
    always @(negedge ap_clk) begin
        have0 = 1'b0;
        have1 = 1'b0;
        if (edge_rst) begin
            mv0 = 0; md0 = 0; mo0 = 0;
            mv1 = 0; md1 = 0; mo1 = 0;
        end else if (edge_en) begin
            if (q0.size() > 0 && q0[0].due == en_edges) begin
                e0 = q0.pop_front(); have0 = 1'b1;
            end
            if (q1.size() > 0 && q1[0].due == en_edges) begin
                e1 = q1.pop_front(); have1 = 1'b1;
            end
            mv0 = have0; mo0 = have0 ? e0.ovf : 1'b0;
            if (have0) md0 = e0.val;
            mv1 = have1; mo1 = have1 ? e1.ovf : 1'b0;
            if (have1) md1 = e1.val;
        end
        chk("dut0_out_valid", longint'(out_valid0), longint'(mv0));
        chk("dut0_dout", longint'($signed(dout0)), md0);
        chk("dut0_ovf", longint'(ovf0), longint'(mo0));
        chk("dut1_out_valid", longint'(out_valid1), longint'(mv1));
        chk("dut1_dout", longint'($signed(dout1)), md1);
        chk("dut1_ovf", longint'(ovf1), longint'(mo1));
        if (edge_en && (have0 || have1))
            $display("[TB] out t=%0t dut0 v=%0b d=%0d | dut1 v=%0b d=%0d",
                     $time, out_valid0, $signed(dout0), out_valid1, $signed(dout1));
    end

    initial begin
        step(1'b1, 1'b1, 1'b0, 16'h0, 9'h0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 16'h1234, 9'h55, 1'b1, 1'b1);
        idle(2, 1'b1);

        // Single tap
        tap(-16'sd3, 9'd200, 1'b1, 1'b1);
        idle(4, 1'b1);

        // Four-tap group followed immediately by a single-tap group
        tap(16'sd100, 9'd10,  1'b1, 1'b0);
        tap(-16'sd50, 9'd20,  1'b0, 1'b0);
        tap(16'sd7,   9'd300, 1'b0, 1'b0);
        tap(16'sd1,   9'd511, 1'b0, 1'b1);
        tap(16'sd2,   9'd5,   1'b1, 1'b1);
        idle(4, 1'b1);

        // Extreme operands
        tap(16'h8000, 9'h1FF, 1'b1, 1'b1);
        idle(4, 1'b1);

        // Bubbles plus a five-cycle stall mid-pipe, then a stall holding out_valid
        tap(16'sd100, 9'd10,  1'b1, 1'b0);
        idle(1, 1'b1);
        tap(-16'sd50, 9'd20,  1'b0, 1'b0);
        idle(2, 1'b1);
        tap(16'sd7,   9'd300, 1'b0, 1'b0);
        tap(16'sd1,   9'd511, 1'b0, 1'b1);
        idle(5, 1'b0);
        idle(2, 1'b1);
        idle(3, 1'b0);
        idle(3, 1'b1);

        // Two large taps overflow the output width
        tap(16'h8000, 9'h1FF, 1'b1, 1'b0);
        tap(16'h8000, 9'h1FF, 1'b0, 1'b1);
        idle(4, 1'b1);

        // Reset mid-group; remaining taps form a group on their own
        tap(16'sd100, 9'd10, 1'b1, 1'b0);
        tap(-16'sd50, 9'd20, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 16'h0, 9'h0, 1'b0, 1'b0);
        tap(16'sd7, 9'd300, 1'b0, 1'b0);
        tap(16'sd1, 9'd511, 1'b0, 1'b1);
        idle(4, 1'b1);

        // first mid-group discards the partial sum
        tap(16'sd1000, 9'd100, 1'b1, 1'b0);
        tap(16'sd2000, 9'd50,  1'b0, 1'b0);
        tap(16'sd3,    9'd4,   1'b1, 1'b0);
        tap(16'sd5,    9'd6,   1'b0, 1'b1);
        idle(4, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 250) == 0, ($urandom % 5) != 0, ($urandom % 5) != 0,
                 16'($urandom), 9'($urandom), ($urandom % 4) == 0, ($urandom % 3) == 0);
        end
        idle(8, 1'b1);

        chk("dut0_queue_drained", longint'(q0.size()), 0);
        chk("dut1_queue_drained", longint'(q1.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end
endmodule
